exmem_skid_stage: RTL and testbench

- Parametrised, elastic successor to the fixed EX/MEM pipeline register.
- Carries a packed EX/MEM payload with valid/ready flow control through a 2-entry skid buffer, so MEM-stage back-pressure never forms a combinational path to EX.
- Adds synchronous flush for branch/exception kill, a hazard-detection tap on the head entry, an occupancy output and a saturating flushed-entry counter.

---
 rtl/exmem_skid_stage.sv | 116 +++++++++++
 tb/tb_exmem_skid_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline stage with a two-entry skid buffer, synchronous flush,
// hazard-detection tap on the head entry, occupancy and flushed-entry count.
module exmem_skid_stage #(
    parameter int unsigned DATA_W      = 172,
    parameter int unsigned RD_LSB      = 160,
    parameter int unsigned RD_W        = 5,
    parameter int unsigned WE_BIT      = 165,
    parameter int unsigned BUBBLE_ZERO = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [RD_W-1:0]   hz_rd,
    output logic              hz_we,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  flush_drops
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] SAT = {2'b00, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  main_q;
    logic [DATA_W-1:0]  skid_q;
    logic [CNT_W-1:0]   drops_q;

    logic               in_fire;
    logic               out_fire;
    logic [1:0]         drop_inc;
    logic [SUM_W-1:0]   drop_sum;
    logic [CNT_W-1:0]   drop_next;

    // Handshake status comes only from registered state, so MEM stall never reaches EX.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        occ = 2'd0;
        case (state)
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    // An entry leaving to MEM in the flush cycle was consumed, not dropped.
    assign drop_inc  = occ - {1'b0, out_fire};
    assign drop_sum  = {2'b00, drops_q} + {{CNT_W{1'b0}}, drop_inc};
    assign drop_next = (drop_sum > SAT) ? SAT[CNT_W-1:0] : drop_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            drops_q <= '0;
        end else if (flush) begin
            state   <= EMPTY;
            drops_q <= drop_next;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (out_fire) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Head payload, optionally forced to zero while the stage holds a bubble.
    always_comb begin
        out_data = main_q;
        if ((BUBBLE_ZERO != 0) && !out_valid) begin
            out_data = '0;
        end
    end

    assign hz_rd       = out_valid ? main_q[RD_LSB +: RD_W] : '0;
    assign hz_we       = main_q[WE_BIT] & out_valid;
    assign flush_drops = drops_q;

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Bench for exmem_skid_stage: directed plan with literal expectations plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_exmem_skid_stage;

    localparam int unsigned DATA_W = 172;
    localparam int unsigned RD_LSB = 160;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned WE_BIT = 165;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned SATV   = (1 << CNT_W) - 1;

    typedef logic [DATA_W-1:0] pl_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    pl_t               in_data;
    logic              out_valid;
    logic              out_ready;
    pl_t               out_data;
    logic              flush;
    logic [RD_W-1:0]   hz_rd;
    logic              hz_we;
    logic [1:0]        occ;
    logic [CNT_W-1:0]  flush_drops;

    exmem_skid_stage #(
        .DATA_W(DATA_W), .RD_LSB(RD_LSB), .RD_W(RD_W), .WE_BIT(WE_BIT),
        .BUBBLE_ZERO(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .hz_rd(hz_rd), .hz_we(hz_we),
        .occ(occ), .flush_drops(flush_drops)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents and drop counter.
    pl_t         q[$];
    int unsigned m_drops;
    bit          m_last_ifire;
    bit          chk_en;
    int          checks;
    int          failures;

    function automatic void chk(input string name, input pl_t act, input pl_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step();
        int sz;
        bit ifire;
        bit ofire;
        sz    = q.size();
        ifire = in_valid && (sz < 2);
        ofire = out_ready && (sz > 0);
        m_last_ifire = ifire;
        if (!rst_n) begin
            q.delete();
            m_drops = 0;
            m_last_ifire = 1'b0;
        end else if (flush) begin
            m_drops = m_drops + sz - (ofire ? 1 : 0);
            if (m_drops > SATV) m_drops = SATV;
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back(in_data);
        end
    endfunction

    task automatic cyc(input logic iv, input pl_t id, input logic ordy,
                       input logic fl, input logic rn);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            pl_t head;
            logic [RD_W-1:0] head_rd;
            head    = (q.size() != 0) ? q[0] : '0;
            head_rd = head[RD_LSB +: RD_W];
            chk("m_out_valid", pl_t'(out_valid), pl_t'(q.size() != 0));
            chk("m_in_ready", pl_t'(in_ready), pl_t'(q.size() < 2));
            chk("m_occ", pl_t'(occ), pl_t'(q.size()));
            chk("m_out_data", out_data, head);
            chk("m_hz_rd", pl_t'(hz_rd), pl_t'(head_rd));
            chk("m_hz_we", pl_t'(hz_we), pl_t'(head[WE_BIT] && (q.size() != 0)));
            chk("m_flush_drops", pl_t'(flush_drops), pl_t'(m_drops));
        end
    end

    initial begin
        pl_t p;
        logic [191:0] r;
        bit hold;
        checks = 0;
        failures = 0;
        chk_en = 1'b0;
        m_drops = 0;
        m_last_ifire = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        #1;

        // Reset for two cycles.
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_occ", pl_t'(occ), pl_t'(0));
        chk("rst_in_ready", pl_t'(in_ready), pl_t'(1));
        chk("rst_out_valid", pl_t'(out_valid), pl_t'(0));
        chk("rst_out_data", out_data, pl_t'(0));
        chk("rst_drops", pl_t'(flush_drops), pl_t'(0));

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, pl_t'(i), 1'b1, 1'b0, 1'b1);
            chk("stream_data", out_data, pl_t'(i));
            chk("stream_occ", pl_t'(occ), pl_t'(1));
            chk("stream_in_ready", pl_t'(in_ready), pl_t'(1));
        end
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("stream_drain", pl_t'(out_valid), pl_t'(0));

        // Back-pressure fill then drain in order.
        cyc(1'b1, pl_t'(8'h11), 1'b0, 1'b0, 1'b1);
        chk("bp_occ1", pl_t'(occ), pl_t'(1));
        cyc(1'b1, pl_t'(8'h22), 1'b0, 1'b0, 1'b1);
        chk("bp_occ2", pl_t'(occ), pl_t'(2));
        chk("bp_in_ready", pl_t'(in_ready), pl_t'(0));
        cyc(1'b1, pl_t'(8'h33), 1'b0, 1'b0, 1'b1);
        chk("bp_hold_head", out_data, pl_t'(8'h11));
        cyc(1'b1, pl_t'(8'h33), 1'b1, 1'b0, 1'b1);
        chk("bp_out_b", out_data, pl_t'(8'h22));
        cyc(1'b1, pl_t'(8'h33), 1'b1, 1'b0, 1'b1);
        chk("bp_out_c", out_data, pl_t'(8'h33));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("bp_empty", pl_t'(occ), pl_t'(0));

        // Flush while FULL with a simultaneous input.
        cyc(1'b1, pl_t'(8'h11), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, pl_t'(8'h22), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, pl_t'(8'h44), 1'b0, 1'b1, 1'b1);
        chk("fl_out_valid", pl_t'(out_valid), pl_t'(0));
        chk("fl_occ", pl_t'(occ), pl_t'(0));
        chk("fl_drops", pl_t'(flush_drops), pl_t'(2));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("fl_no_d", out_data, pl_t'(0));

        // Flush together with out_fire in ONE.
        cyc(1'b1, pl_t'(8'h55), 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("flo_drops", pl_t'(flush_drops), pl_t'(2));
        chk("flo_occ", pl_t'(occ), pl_t'(0));

        // Hazard tap.
        p = '0;
        p[RD_LSB +: RD_W] = 5'd7;
        p[WE_BIT] = 1'b1;
        p[31:0] = 32'h0000_0abc;
        cyc(1'b1, p, 1'b0, 1'b0, 1'b1);
        chk("hz_rd7", pl_t'(hz_rd), pl_t'(7));
        chk("hz_we1", pl_t'(hz_we), pl_t'(1));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("hz_rd0", pl_t'(hz_rd), pl_t'(0));
        chk("hz_we0", pl_t'(hz_we), pl_t'(0));
        chk("hz_bubble", out_data, pl_t'(0));

        // Saturation, then reset overriding flush while FULL.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, pl_t'(k + 1), 1'b0, 1'b0, 1'b1);
            cyc(1'b1, pl_t'(k + 9), 1'b0, 1'b0, 1'b1);
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        end
        chk("sat_drops", pl_t'(flush_drops), pl_t'(3));
        cyc(1'b1, pl_t'(8'h66), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, pl_t'(8'h77), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, pl_t'(8'h88), 1'b1, 1'b1, 1'b0);
        chk("rp_drops", pl_t'(flush_drops), pl_t'(0));
        chk("rp_occ", pl_t'(occ), pl_t'(0));
        chk("rp_in_ready", pl_t'(in_ready), pl_t'(1));
        chk("rp_out_data", out_data, pl_t'(0));

        // Randomized traffic; a refused offer is held until accepted.
        for (int i = 0; i < 3000; i++) begin
            hold = in_valid && !m_last_ifire && rst_n;
            r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (hold) p = in_data;
            else p = r[DATA_W-1:0];
            cyc(hold ? 1'b1 : ($urandom_range(0, 9) < 7), p,
                ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 99) < 4),
                !($urandom_range(0, 199) < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
